// File: rtl/traffic_light_pkg.sv
// Shared light-code constants, violation codes and legality helpers for the
// junction light-bus monitor.
package traffic_light_pkg;

  localparam logic [2:0] LT_R  = 3'b100;
  localparam logic [2:0] LT_RA = 3'b110;
  localparam logic [2:0] LT_G  = 3'b001;
  localparam logic [2:0] LT_A  = 3'b010;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ENC      = 3'd1,
    ERR_TRANS    = 3'd2,
    ERR_CONFLICT = 3'd3,
    ERR_HOLD     = 3'd4
  } err_code_t;

  function automatic logic is_legal_code(input logic [2:0] code);
    logic legal;
    case (code)
      LT_R, LT_RA, LT_G, LT_A: legal = 1'b1;
      default:                 legal = 1'b0;
    endcase
    return legal;
  endfunction

  // A light may repeat its code or advance one step around R->RA->G->A->R.
  function automatic logic is_legal_transition(input logic [2:0] prev,
                                               input logic [2:0] cur);
    logic ok;
    case (prev)
      LT_R:    ok = (cur == LT_R)  || (cur == LT_RA);
      LT_RA:   ok = (cur == LT_RA) || (cur == LT_G);
      LT_G:    ok = (cur == LT_G)  || (cur == LT_A);
      LT_A:    ok = (cur == LT_A)  || (cur == LT_R);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/light_tracker.sv
// Per-light tracker: remembers the last legal code and its run length, flags
// encoding/transition/hold problems on the current sample and counts cycles.
module light_tracker
  import traffic_light_pkg::*;
#(
  parameter int COUNT_W  = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         code_i,
  output logic               enc_err_o,
  output logic               trans_err_o,
  output logic               hold_err_o,
  output logic               red_o,
  output logic [COUNT_W-1:0] cycles_o
);

  logic [2:0]         prev_q, prev_d;
  logic [7:0]         hold_q, hold_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               legal;
  logic               same;

  // Illegal samples leave prev/hold untouched so tracking resumes cleanly.
  always_comb begin
    legal       = is_legal_code(code_i);
    same        = legal && (code_i == prev_q);
    enc_err_o   = !legal;
    trans_err_o = legal && !is_legal_transition(prev_q, code_i);
    hold_err_o  = same && (hold_q == 8'(MAX_HOLD));
    red_o       = code_i[2];
    prev_d      = prev_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    if (legal) begin
      prev_d = code_i;
      if (same) begin
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
      end else begin
        hold_d = 8'd1;
      end
      if ((prev_q == LT_A) && (code_i == LT_R) && (cnt_q != '1)) begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= LT_R;
      hold_q <= 8'd0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cycles_o = cnt_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the two-way junction light bus: latches the
// first violation (sticky) and reports per-direction completed cycles.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int COUNT_W  = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         lightsA,
  input  logic [2:0]         lightsB,
  input  logic               clr_err,
  output logic               error,
  output logic [2:0]         err_code,
  output logic               err_light,
  output logic [COUNT_W-1:0] cyclesA,
  output logic [COUNT_W-1:0] cyclesB
);

  logic      encA, transA, holdA, redA;
  logic      encB, transB, holdB, redB;
  logic      viol;
  err_code_t violCode;
  logic      violLight;
  logic      error_q, error_d;
  err_code_t code_q, code_d;
  logic      light_q, light_d;

  light_tracker #(.COUNT_W(COUNT_W), .MAX_HOLD(MAX_HOLD)) trackerA (
    .clk(clk), .rst(rst), .code_i(lightsA),
    .enc_err_o(encA), .trans_err_o(transA), .hold_err_o(holdA),
    .red_o(redA), .cycles_o(cyclesA)
  );

  light_tracker #(.COUNT_W(COUNT_W), .MAX_HOLD(MAX_HOLD)) trackerB (
    .clk(clk), .rst(rst), .code_i(lightsB),
    .enc_err_o(encB), .trans_err_o(transB), .hold_err_o(holdB),
    .red_o(redB), .cycles_o(cyclesB)
  );

  // Priority: encoding > conflict > transition > hold; A before B within a
  // class. A fresh violation is latched even when clr_err is asserted.
  always_comb begin
    viol      = 1'b1;
    violCode  = ERR_NONE;
    violLight = 1'b0;
    if (encA) begin
      violCode = ERR_ENC;
    end else if (encB) begin
      violCode  = ERR_ENC;
      violLight = 1'b1;
    end else if (!redA && !redB) begin
      violCode = ERR_CONFLICT;
    end else if (transA) begin
      violCode = ERR_TRANS;
    end else if (transB) begin
      violCode  = ERR_TRANS;
      violLight = 1'b1;
    end else if (holdA) begin
      violCode = ERR_HOLD;
    end else if (holdB) begin
      violCode  = ERR_HOLD;
      violLight = 1'b1;
    end else begin
      viol = 1'b0;
    end

    error_d = error_q;
    code_d  = code_q;
    light_d = light_q;
    if (viol && (!error_q || clr_err)) begin
      error_d = 1'b1;
      code_d  = violCode;
      light_d = violLight;
    end else if (clr_err) begin
      error_d = 1'b0;
      code_d  = ERR_NONE;
      light_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
      light_q <= 1'b0;
    end else begin
      error_q <= error_d;
      code_q  <= code_d;
      light_q <= light_d;
    end
  end

  assign error     = error_q;
  assign err_code  = code_q;
  assign err_light = light_q;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the two-way junction light bus: samples the lightsA/lightsB codes every clock and checks encoding legality, per-light sequence order, mutual safety and hold time.
Reports the first violation (sticky, with code and light ID) and counts completed light cycles per direction.
It is the consuming end of the light-controller interface, used in-system as a safety watchdog and on benches as a scoreboard.

Parameters:
COUNT_W, 8, width of the per-light cycle counters (saturating).
MAX_HOLD, 8, maximum number of consecutive cycles any light may show the same legal code; range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
lightsA  input  3  light A code, bit2=red, bit1=amber, bit0=green
lightsB  input  3  light B code, same encoding
clr_err  input  1  synchronous clear of the sticky error state
error  output  1  sticky violation flag
err_code  output  3  code of the first violation: 0 none, 1 bad encoding, 2 bad transition, 3 conflict, 4 hold timeout
err_light  output  1  light that caused it: 0=A, 1=B; always 0 for a conflict
cyclesA  output  COUNT_W  completed cycles of light A (amber->red transitions), saturating
cyclesB  output  COUNT_W  completed cycles of light B, saturating

Behaviour:
- Legal codes: R=100, RA=110, G=001, A=010. Every other code is illegal.
- Legal transitions, from the previous legal code to the current sample:
  - R->R or RA
  - RA->RA or G
  - G->G or A
  - A->A or R
- Per-light state:
  - prev code, reset to R.
  - hold_cnt (8 bit), reset to 0.
  - An illegal sample updates neither prev nor hold_cnt.
  - A legal sample equal to prev: hold_cnt <= hold_cnt+1. A legal sample different from prev: hold_cnt <= 1.
- Checks, evaluated every clock on the current samples:
  - bad encoding: the sample is illegal.
  - conflict: red bit clear on both lights simultaneously.
  - bad transition: legal sample, not in the allowed set from prev.
  - hold timeout: sample equals prev and hold_cnt==MAX_HOLD, i.e. the (MAX_HOLD+1)th identical consecutive sample.
- Priority when several checks fire in one cycle:
  - Across checks: encoding > conflict > transition > timeout.
  - Within the same check: light A beats light B.
- Error recording:
  - All outputs are registered; error rises one clock after the offending sample edge.
  - When error=0, the first violation latches error=1, err_code and err_light.
  - Later violations do not overwrite the latched values.
  - clr_err=1 returns error, err_code and err_light to 0 on the next edge.
  - If clr_err and a new violation occur in the same cycle, the new violation is latched; the violation wins.
  - Tracking (prev, hold_cnt, counters) continues regardless of error or clr_err.
- Cycle counters: a legal A->R transition increments cyclesX. The counter saturates at 2^COUNT_W-1 and never wraps.
- Reset values: error=0, err_code=0, err_light=0, cyclesA=0, cyclesB=0, both prev=R, both hold_cnt=0.
- Reset asserted mid-operation clears everything immediately (asynchronous); the first sample after release is checked against prev=R.
- hold_cnt saturates at 255 so it cannot wrap once a timeout has fired.

Decomposition:
- Package traffic_light_pkg:
  - Light code constants LT_R, LT_RA, LT_G, LT_A.
  - Enum err_code_t with ERR_NONE, ERR_ENC, ERR_TRANS, ERR_CONFLICT, ERR_HOLD.
  - Function is_legal_code.
  - Function is_legal_transition(prev, cur).
- Sub-module light_tracker, instantiated once per light:
  - Holds prev, hold_cnt and the saturating cycle counter.
  - Emits per-light enc_err, trans_err, hold_err and red flags.
- The top level holds the conflict check, the priority encoder and the sticky error register.

Test Plan:
- Reset, then drive the nominal 8-step pattern for 80 cycles:
  - A: R,R,R,R,RA,G,A,R
  - B: RA,G,A,R,R,R,R,R
  - Required: error stays 0, and cyclesA=cyclesB=10 after the 80 cycles.
- Drive A=011 for one cycle, B legal -> error=1 next cycle, err_code=1, err_light=0. Restoring legal input does not clear it.
- Drive A=G and B=G in the same cycle, A's transition also illegal -> err_code=3 (conflict beats transition), err_light=0.
- A holds R for 9 cycles with MAX_HOLD=8 -> error rises after the 9th sample, err_code=4. Holding R for exactly 8 cycles gives no error.
- B goes R->G directly -> err_code=2, err_light=1. In the same run, assert clr_err with no new violation -> error=0, err_code=0 next cycle.
- With COUNT_W=3, run 10 A cycles -> cyclesA=7 (saturated). Then assert rst mid-pattern -> all outputs 0 immediately, with no clock edge needed.
